game_loop_controller: RTL and testbench
=======================================

// Module: game_loop_controller
// PURPOSE
//  Central game-loop block for the Doodle Jump top level, generalised to N_PLAYERS doodles.
//  - Generates the per-frame physics tick and runs the game-state FSM (IDLE/PLAY/PAUSE/OVER).
//  - Commits state changes only on VGA frame boundaries.
//  - Produces per-player horizontal velocity from buttons, and keeps per-player saturating scores.
//  - Sits between board_specific (buttons) and the doodle/platforms/collision blocks.
// PARAMETERS
//  CLK        50000000  input clock frequency, Hz
//  FPS        50        physics tick rate; TICK_DIV = CLK/FPS, must be >= 2
//  N_PLAYERS  2         number of independently controlled doodles, 1..4
//  DX_MAX     7         |delta_x| limit, 1..7
//  SCORE_W    16        score counter width
// PORTS
//  clk          in   1              system clock
//  rst          in   1              synchronous, active-high reset
//  frame_start  in   1              1-cycle pulse at start of vertical sync
//  btn_start    in   1              level, debounced
//  btn_pause    in   1              level, debounced
//  btn_left     in   N_PLAYERS      level, per player
//  btn_right    in   N_PLAYERS      level, per player
//  player_fell  in   N_PLAYERS      1-cycle pulse: doodle i left the screen bottom
//  score_inc    in   N_PLAYERS      1-cycle pulse: add score_amt[i] to player i
//  score_amt    in   N_PLAYERS x 8  unsigned increment per player
//  tick         out  1              1-cycle physics pulse; asserted only in PLAY
//  game_state   out  2              0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
//  alive        out  N_PLAYERS      per-player alive mask
//  delta_x      out  N_PLAYERS x 4  signed per-player velocity, range [-DX_MAX, DX_MAX]
//  score        out  N_PLAYERS x SCORE_W  per-player score
//  frame_count  out  16             frames elapsed in PLAY
//  winner       out  2              index of highest score, valid in OVER
// BEHAVIOUR
//  Reset values:
//  - game_state=IDLE, alive=0, delta_x=0, score=0, frame_count=0, winner=0, tick=0.
//  - Divider=0; pending request cleared; button edge registers = 0.
//  Divider:
//  - Free-running 0..TICK_DIV-1; wraps to 0.
//  - tick=1 for the single cycle the divider equals TICK_DIV-1 AND state==PLAY.
//  Buttons:
//  - btn_start/btn_pause rising edges come from a 1-cycle registered compare.
//  - The edge pulse is valid the cycle after the input rises.
//  FSM requests:
//  - A rising edge latches a pending request (START or PAUSE); a newer edge overwrites an older one.
//  - The request is applied in the cycle frame_start=1 and is visible on game_state the next cycle.
//  - IDLE  + START -> PLAY. On entry: alive=all 1s, score=0, frame_count=0, delta_x=0.
//  - PLAY  + PAUSE -> PAUSE.
//  - PAUSE + PAUSE -> PLAY.
//  - OVER  + START -> IDLE.
//  - Any other request/state pair is discarded at frame_start.
//  - PLAY -> OVER when alive==0. This is checked at frame_start and has priority over a pending PAUSE.
//  - On entry to OVER, winner is registered: index of max score, ties -> lowest index.
//  player_fell[i]:
//  - Clears alive[i] in PLAY only. In the same cycle it also forces delta_x[i] to 0.
//  - Ignored in all other states.
//  delta_x[i]:
//  - Updates on tick only.
//  - left&~right: decrement, clamped at -DX_MAX.
//  - right&~left: increment, clamped at +DX_MAX.
//  - Neither or both pressed: move 1 toward 0.
//  - Held at 0 while alive[i]=0; forced 0 in IDLE/OVER; held (frozen) in PAUSE.
//  score[i]:
//  - In PLAY with alive[i]=1: score_inc adds score_amt, saturating at 2^SCORE_W-1.
//  - score_inc coinciding with player_fell: the increment is applied.
//  - Scores hold in PAUSE/OVER and clear only on IDLE->PLAY.
//  frame_count: +1 per frame_start while PLAY; wraps at 0xFFFF.
//  Reset mid-game: all of the above return to reset values next cycle; any pending request is lost.
// TESTING  (CLK=100, FPS=10 -> TICK_DIV=10; N_PLAYERS=2, DX_MAX=7, SCORE_W=8)
//  1. Pulse btn_start, then frame_start 20 cycles later.
//     -> game_state=1 the cycle after frame_start; alive=2'b11.
//     -> tick every 10 cycles thereafter and never before PLAY.
//  2. Hold btn_right[0] for 9 ticks.
//     -> delta_x[0] goes 1..7 and stays 7.
//     -> On release, decays 6,5..0 (one step per tick); delta_x[1] stays 0.
//  3. In PLAY, pulse btn_pause then frame_start.
//     -> state=2, tick suppressed, delta_x frozen.
//     -> A second pause edge + frame_start gives state=1.
//  4. score_amt[1]=200 with score_inc twice.
//     -> score[1]=255 (saturated); score[0]=0.
//  5. player_fell[0], then player_fell[1] with a btn_pause edge pending, then frame_start.
//     -> state=3 (not PAUSE); winner=1; delta_x both 0.
//  6. rst asserted while in PAUSE with a request pending.
//     -> next cycle all outputs at reset values.
//     -> frame_start alone does not leave IDLE.

Source files
------------

// File: rtl/game_loop_controller.sv
// Game-loop core: physics tick divider, frame-synchronous game-state FSM,
// per-player velocity and saturating score lanes.
module game_loop_controller #(
  parameter int CLK       = 50000000,
  parameter int FPS       = 50,
  parameter int N_PLAYERS = 2,
  parameter int DX_MAX    = 7,
  parameter int SCORE_W   = 16
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  input  logic                              btn_start,
  input  logic                              btn_pause,
  input  logic [N_PLAYERS-1:0]              btn_left,
  input  logic [N_PLAYERS-1:0]              btn_right,
  input  logic [N_PLAYERS-1:0]              player_fell,
  input  logic [N_PLAYERS-1:0]              score_inc,
  input  logic [N_PLAYERS-1:0][7:0]         score_amt,
  output logic                              tick,
  output logic [1:0]                        game_state,
  output logic [N_PLAYERS-1:0]              alive,
  output logic [N_PLAYERS-1:0][3:0]         delta_x,
  output logic [N_PLAYERS-1:0][SCORE_W-1:0] score,
  output logic [15:0]                       frame_count,
  output logic [1:0]                        winner
);
  localparam int TICK_DIV = CLK / FPS;
  localparam int DIV_W    = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [1:0] REQ_NONE  = 2'd0;
  localparam logic [1:0] REQ_START = 2'd1;
  localparam logic [1:0] REQ_PAUSE = 2'd2;

  logic [DIV_W-1:0] div;
  logic             start_d, pause_d, start_edge, pause_edge;
  logic [1:0]       req;
  logic [1:0]       state_nxt;
  logic             enter_play, enter_over;
  logic [1:0]       winner_nxt;
  logic [SCORE_W-1:0] best;

  always_ff @(posedge clk) begin
    if (rst || div == DIV_W'(TICK_DIV - 1)) div <= '0;
    else                                    div <= div + 1'b1;
  end

  assign tick = (div == DIV_W'(TICK_DIV - 1)) && (game_state == S_PLAY);

  // Game over wins over any pending request once everybody has fallen.
  always_comb begin
    state_nxt = game_state;
    if (frame_start) begin
      if (game_state == S_PLAY && alive == '0) state_nxt = S_OVER;
      else begin
        case ({game_state, req})
          {S_IDLE,  REQ_START}: state_nxt = S_PLAY;
          {S_PLAY,  REQ_PAUSE}: state_nxt = S_PAUSE;
          {S_PAUSE, REQ_PAUSE}: state_nxt = S_PLAY;
          {S_OVER,  REQ_START}: state_nxt = S_IDLE;
          default:              state_nxt = game_state;
        endcase
      end
    end
  end

  assign enter_play = (game_state == S_IDLE) && (state_nxt == S_PLAY);
  assign enter_over = (game_state != S_OVER) && (state_nxt == S_OVER);

  // Strictly-greater compare keeps ties on the lowest index.
  always_comb begin
    winner_nxt = 2'd0;
    best       = score[0];
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (score[i] > best) begin
        best       = score[i];
        winner_nxt = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d     <= 1'b0;
      pause_d     <= 1'b0;
      start_edge  <= 1'b0;
      pause_edge  <= 1'b0;
      req         <= REQ_NONE;
      game_state  <= S_IDLE;
      frame_count <= '0;
      winner      <= '0;
    end else begin
      start_d    <= btn_start;
      pause_d    <= btn_pause;
      start_edge <= btn_start & ~start_d;
      pause_edge <= btn_pause & ~pause_d;
      game_state <= state_nxt;
      if (pause_edge)       req <= REQ_PAUSE;
      else if (start_edge)  req <= REQ_START;
      else if (frame_start) req <= REQ_NONE;
      if (enter_play)                               frame_count <= '0;
      else if (frame_start && game_state == S_PLAY) frame_count <= frame_count + 16'd1;
      if (enter_over) winner <= winner_nxt;
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
    localparam logic signed [3:0] DXM = 4'(DX_MAX);
    logic                alive_r;
    logic signed [3:0]   dx_r, dx_nxt;
    logic [SCORE_W-1:0]  sc_r;
    logic [SCORE_W:0]    sum;

    assign sum = {1'b0, sc_r} + {{(SCORE_W - 7){1'b0}}, score_amt[i]};

    always_comb begin
      dx_nxt = dx_r;
      if (btn_left[i] && !btn_right[i]) begin
        if (dx_r > -DXM) dx_nxt = dx_r - 4'sd1;
      end else if (btn_right[i] && !btn_left[i]) begin
        if (dx_r < DXM) dx_nxt = dx_r + 4'sd1;
      end else if (dx_r > 4'sd0) dx_nxt = dx_r - 4'sd1;
      else if (dx_r < 4'sd0)     dx_nxt = dx_r + 4'sd1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        alive_r <= 1'b0;
        dx_r    <= '0;
        sc_r    <= '0;
      end else if (enter_play) begin
        alive_r <= 1'b1;
        dx_r    <= '0;
        sc_r    <= '0;
      end else if (game_state == S_PLAY) begin
        if (player_fell[i]) alive_r <= 1'b0;
        if (player_fell[i] || !alive_r) dx_r <= '0;
        else if (tick)                  dx_r <= dx_nxt;
        if (score_inc[i] && alive_r)
          sc_r <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end else if (game_state != S_PAUSE) begin
        dx_r <= '0;
      end
    end

    assign alive[i]   = alive_r;
    assign delta_x[i] = dx_r;
    assign score[i]   = sc_r;
  end
endmodule

// File: tb/tb_game_loop_controller.sv
// Directed bench: per-cycle compare against a behavioural game model plus literal checks.
module tb_game_loop_controller;
  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
  logic [1:0] btn_left = '0, btn_right = '0, player_fell = '0, score_inc = '0;
  logic [1:0][7:0] score_amt = '0;
  logic tick;
  logic [1:0] game_state, alive, winner;
  logic [1:0][3:0] delta_x;
  logic [1:0][7:0] score;
  logic [15:0] frame_count;

  int nchk = 0, nerr = 0;

  game_loop_controller #(.CLK(100), .FPS(10), .N_PLAYERS(2), .DX_MAX(7), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_left(btn_left), .btn_right(btn_right), .player_fell(player_fell), .score_inc(score_inc),
    .score_amt(score_amt), .tick(tick), .game_state(game_state), .alive(alive), .delta_x(delta_x),
    .score(score), .frame_count(frame_count), .winner(winner));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: states 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER; requests 0 none, 1 start, 2 pause.
  int m_state = 0, m_cnt = 0, m_fc = 0, m_win = 0, m_req = 0;
  bit m_sd = 0, m_pd = 0, m_se = 0, m_pe = 0;
  int m_alive[2] = '{0, 0}, m_dx[2] = '{0, 0}, m_score[2] = '{0, 0};

  task automatic model_step();
    int ns; bit tk, ent_play, was_alive, l, r;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_fc = 0; m_win = 0; m_req = 0;
      m_sd = 0; m_pd = 0; m_se = 0; m_pe = 0;
      for (int i = 0; i < 2; i++) begin m_alive[i] = 0; m_dx[i] = 0; m_score[i] = 0; end
      return;
    end
    tk = (m_cnt == 9) && (m_state == 1);
    ns = m_state; ent_play = 0;
    if (frame_start) begin
      if (m_state == 1 && m_alive[0] == 0 && m_alive[1] == 0) begin
        ns = 3;
        m_win = (m_score[1] > m_score[0]) ? 1 : 0;
      end
      else if (m_state == 0 && m_req == 1) begin ns = 1; ent_play = 1; end
      else if (m_state == 1 && m_req == 2) ns = 2;
      else if (m_state == 2 && m_req == 2) ns = 1;
      else if (m_state == 3 && m_req == 1) ns = 0;
    end
    if (ent_play) m_fc = 0;
    else if (frame_start && m_state == 1) m_fc = (m_fc + 1) % 65536;
    for (int i = 0; i < 2; i++) begin
      if (ent_play) begin m_alive[i] = 1; m_dx[i] = 0; m_score[i] = 0; end
      else if (m_state == 1) begin
        was_alive = m_alive[i] != 0;
        l = btn_left[i]; r = btn_right[i];
        if (player_fell[i]) begin m_alive[i] = 0; m_dx[i] = 0; end
        else if (!was_alive) m_dx[i] = 0;
        else if (tk) begin
          if (l && !r)      m_dx[i] = (m_dx[i] > -7) ? m_dx[i] - 1 : -7;
          else if (r && !l) m_dx[i] = (m_dx[i] < 7) ? m_dx[i] + 1 : 7;
          else if (m_dx[i] > 0) m_dx[i]--;
          else if (m_dx[i] < 0) m_dx[i]++;
        end
        if (score_inc[i] && was_alive) begin
          m_score[i] += score_amt[i];
          if (m_score[i] > 255) m_score[i] = 255;
        end
      end
      else if (m_state != 2) m_dx[i] = 0;
    end
    if (m_pe) m_req = 2;
    else if (m_se) m_req = 1;
    else if (frame_start) m_req = 0;
    m_se = btn_start && !m_sd; m_sd = btn_start;
    m_pe = btn_pause && !m_pd; m_pd = btn_pause;
    m_cnt = (m_cnt + 1) % 10;
    m_state = ns;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("tick", int'(tick), int'(m_cnt == 9 && m_state == 1));
    chk("game_state", int'(game_state), m_state);
    chk("alive", int'(alive), m_alive[1] * 2 + m_alive[0]);
    chk("delta_x0", int'($signed(delta_x[0])), m_dx[0]);
    chk("delta_x1", int'($signed(delta_x[1])), m_dx[1]);
    chk("score0", int'(score[0]), m_score[0]);
    chk("score1", int'(score[1]), m_score[1]);
    chk("frame_count", int'(frame_count), m_fc);
    chk("winner", int'(winner), m_win);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; cyc(1); frame_start = 1'b0; cyc(1);
  endtask

  task automatic pulse_start();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0; cyc(3);
  endtask

  task automatic pulse_pause();
    btn_pause = 1'b1; cyc(1); btn_pause = 1'b0; cyc(3);
  endtask

  // Returns at the negedge after the tick cycle, once delta_x has updated.
  task automatic wait_tick();
    int k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 30);
    if (!tick) chk("tick_timeout", 0, 1);
    else @(negedge clk);
  endtask

  initial begin
    int frozen;
    cyc(3);
    chk("rst_state", int'(game_state), 0);
    chk("rst_alive", int'(alive), 0);
    chk("rst_tick", int'(tick), 0);
    rst = 1'b0;

    // 1: start request waits for a frame boundary
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(20);
    chk("idle_before_frame", int'(game_state), 0);
    pulse_fs();
    chk("play_state", int'(game_state), 1);
    chk("play_alive", int'(alive), 3);

    // 2: ramp to +7, clamp, then decay
    btn_right[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_tick();
      chk("ramp_dx0", int'($signed(delta_x[0])), (k < 7) ? k : 7);
    end
    btn_right[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      wait_tick();
      chk("decay_dx0", int'($signed(delta_x[0])), 7 - k);
    end
    chk("idle_dx1", int'($signed(delta_x[1])), 0);

    // 3: pause freezes motion, second pause resumes
    btn_right[1] = 1'b1;
    repeat (3) wait_tick();
    chk("dx1_three", int'($signed(delta_x[1])), 3);
    pulse_pause();
    pulse_fs();
    chk("pause_state", int'(game_state), 2);
    frozen = m_dx[1];
    cyc(25);
    chk("frozen_dx1", int'($signed(delta_x[1])), frozen);
    pulse_pause();
    pulse_fs();
    chk("resume_state", int'(game_state), 1);
    btn_right[1] = 1'b0;

    // 4: saturating score
    score_amt[1] = 8'd200;
    score_inc = 2'b10; cyc(1); score_inc = 2'b00; cyc(1);
    chk("score1_200", int'(score[1]), 200);
    score_inc = 2'b10; cyc(1); score_inc = 2'b00; cyc(1);
    chk("score1_sat", int'(score[1]), 255);
    chk("score0_zero", int'(score[0]), 0);
    score_amt[0] = 8'd10;
    score_inc = 2'b01; cyc(1); score_inc = 2'b00; cyc(1);
    chk("score0_10", int'(score[0]), 10);

    // 5: falls, increment on the falling cycle, game over beats pending pause
    score_amt[0] = 8'd3;
    player_fell = 2'b01; score_inc = 2'b01; cyc(1);
    player_fell = 2'b00; score_inc = 2'b00; cyc(1);
    chk("fell0_alive", int'(alive), 2);
    chk("fell0_dx", int'($signed(delta_x[0])), 0);
    chk("fell0_score", int'(score[0]), 13);
    pulse_pause();
    player_fell = 2'b10; cyc(1); player_fell = 2'b00; cyc(2);
    pulse_fs();
    chk("over_state", int'(game_state), 3);
    chk("over_winner", int'(winner), 1);
    chk("over_dx0", int'($signed(delta_x[0])), 0);
    chk("over_dx1", int'($signed(delta_x[1])), 0);
    chk("over_frames", int'(frame_count), 2);

    // OVER -> IDLE -> PLAY clears scores
    pulse_start(); pulse_fs();
    chk("back_idle", int'(game_state), 0);
    pulse_start(); pulse_fs();
    chk("replay_state", int'(game_state), 1);
    chk("replay_score1", int'(score[1]), 0);

    // 6: reset in PAUSE with a request pending
    pulse_pause(); pulse_fs();
    chk("pause_again", int'(game_state), 2);
    btn_pause = 1'b1; cyc(1); btn_pause = 1'b0; cyc(2);
    rst = 1'b1; cyc(1);
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_alive", int'(alive), 0);
    chk("midrst_frames", int'(frame_count), 0);
    chk("midrst_winner", int'(winner), 0);
    rst = 1'b0;
    pulse_fs(); cyc(2);
    chk("no_stale_req", int'(game_state), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
